// File: rtl/sto_sched.sv
// sto_sched: job sequencer for the store/stream datapath.
// For each tile it pulses weight_start, waits for weight_done, then pulses
// act_start and counts ACT_BEATS act_valid beats. After the last tile it
// pulses done. A progress watchdog and a synchronous abort both end the
// job through FIN.
module sto_sched #(
    parameter int ACT_BEATS = 64,
    parameter int TILE_W    = 8,
    parameter int TMO_CYC   = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [TILE_W-1:0] tile_num,
    output logic              weight_start,
    input  logic              weight_done,
    output logic              act_start,
    input  logic              act_valid,
    output logic [TILE_W-1:0] tile_idx,
    output logic              busy,
    output logic              done,
    output logic              err
);
    localparam int BEAT_W = (ACT_BEATS > 1) ? $clog2(ACT_BEATS) : 1;
    localparam int WDOG_W = (TMO_CYC > 2) ? $clog2(TMO_CYC) : 1;

    // The terminal beat is detected before the counter could overflow.
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(ACT_BEATS - 1);
    // The watchdog trips when the next increment would reach TMO_CYC-1.
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TMO_CYC - 2);
    localparam logic [TILE_W-1:0] TILE_ONE  = TILE_W'(1);
    localparam logic [TILE_W-1:0] TILE_ZERO = TILE_W'(0);
    localparam logic [BEAT_W-1:0] BEAT_ONE  = BEAT_W'(1);
    localparam logic [BEAT_W-1:0] BEAT_ZERO = BEAT_W'(0);
    localparam logic [WDOG_W-1:0] WDOG_ONE  = WDOG_W'(1);
    localparam logic [WDOG_W-1:0] WDOG_ZERO = WDOG_W'(0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        W_WAIT = 2'd1,
        A_RUN  = 2'd2,
        FIN    = 2'd3
    } state_t;

    state_t            state_r;
    state_t            next_s;
    logic [TILE_W-1:0] num_r;
    logic [BEAT_W-1:0] beat_r;
    logic [WDOG_W-1:0] wdog_r;

    logic accept_s;
    logic zero_start_s;
    logic progress_s;
    logic last_beat_s;
    logic last_tile_s;
    logic timeout_s;
    logic run_s;
    logic ws_s;
    logic as_s;
    logic done_s;
    logic busy_s;
    logic err_s;

    // Qualify raw inputs against the current state.
    always_comb begin
        run_s        = (state_r == W_WAIT) || (state_r == A_RUN);
        accept_s     = (state_r == IDLE) && start && (tile_num != TILE_ZERO);
        zero_start_s = (state_r == IDLE) && start && (tile_num == TILE_ZERO);
        progress_s   = ((state_r == W_WAIT) && weight_done) ||
                       ((state_r == A_RUN) && act_valid);
        last_beat_s  = (state_r == A_RUN) && act_valid && (beat_r == BEAT_LAST);
        last_tile_s  = (tile_idx == (num_r - TILE_ONE));
        // Progress in the same cycle always beats the watchdog.
        timeout_s    = run_s && !progress_s && (wdog_r == WDOG_LAST);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_s;
        end
    end

    // Next-state logic; abort outranks every other event in a busy state.
    always_comb begin
        next_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) next_s = W_WAIT;
                else          next_s = IDLE;
            end
            W_WAIT: begin
                if (abort || timeout_s) next_s = FIN;
                else if (weight_done)   next_s = A_RUN;
                else                    next_s = W_WAIT;
            end
            A_RUN: begin
                if (abort || timeout_s) next_s = FIN;
                else if (last_beat_s) begin
                    if (last_tile_s) next_s = FIN;
                    else             next_s = W_WAIT;
                end else begin
                    next_s = A_RUN;
                end
            end
            FIN:     next_s = IDLE;
            default: next_s = IDLE;
        endcase
    end

    // Output decode: values the output registers take at the next edge.
    always_comb begin
        ws_s   = (next_s == W_WAIT) && (state_r != W_WAIT);
        as_s   = (next_s == A_RUN) && (state_r != A_RUN);
        done_s = (next_s == FIN) || zero_start_s;
        busy_s = (next_s == W_WAIT) || (next_s == A_RUN);
        if ((state_r == IDLE) && start) err_s = 1'b0;
        else if (timeout_s)             err_s = 1'b1;
        else                            err_s = err;
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            weight_start <= 1'b0;
            act_start    <= 1'b0;
            done         <= 1'b0;
            busy         <= 1'b0;
            err          <= 1'b0;
        end else begin
            weight_start <= ws_s;
            act_start    <= as_s;
            done         <= done_s;
            busy         <= busy_s;
            err          <= err_s;
        end
    end

    // Tile bookkeeping, beat counter and watchdog.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            num_r    <= TILE_ZERO;
            tile_idx <= TILE_ZERO;
            beat_r   <= BEAT_ZERO;
            wdog_r   <= WDOG_ZERO;
        end else begin
            if (accept_s) begin
                num_r    <= tile_num;
                tile_idx <= TILE_ZERO;
            end else if ((state_r == A_RUN) && (next_s == W_WAIT)) begin
                tile_idx <= tile_idx + TILE_ONE;
            end else begin
                tile_idx <= tile_idx;
            end

            if ((state_r == W_WAIT) && (next_s == A_RUN)) begin
                beat_r <= BEAT_ZERO;
            end else if ((state_r == A_RUN) && act_valid && !last_beat_s) begin
                beat_r <= beat_r + BEAT_ONE;
            end else begin
                beat_r <= beat_r;
            end

            if ((next_s != state_r) || progress_s || !run_s) begin
                wdog_r <= WDOG_ZERO;
            end else begin
                wdog_r <= wdog_r + WDOG_ONE;
            end
        end
    end
endmodule
